// File: rtl/mcl_cycle_queue_if.sv
// Request and MBOX-side bus of the MCL memory-cycle queue.
// The BRK_* signals are only consumed when MCL_ADR_BRK_EN is defined.
interface mcl_cycle_queue_if #(
  parameter int unsigned VMA_W = 23,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCOMP = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SEL_W = (NCOMP > 1) ? $clog2(NCOMP) : 1;

  logic             REQ_VALID;
  logic             REQ_READY;
  logic [VMA_W-1:0] REQ_VMA;
  logic [11:0]      REQ_FLAGS;
  logic             MBOX_REQ;
  logic             MBOX_ACK;
  logic [VMA_W-1:0] MBOX_VMA;
  logic [11:0]      MBOX_FLAGS;
  logic [VMA_W-1:0] HELD_VMA;
  logic [11:0]      HELD_FLAGS;
  logic [CNT_W-1:0] COUNT;
  logic             FLUSH;
  logic             BRK_LOAD;
  logic [SEL_W-1:0] BRK_SEL;
  logic [VMA_W-1:0] BRK_VMA;
  logic [2:0]       BRK_MODE;
  logic             BRK_USER;
  logic             PAGE_ADDRESS_COND;

  modport master (
    output REQ_VALID, REQ_VMA, REQ_FLAGS, MBOX_ACK, FLUSH,
           BRK_LOAD, BRK_SEL, BRK_VMA, BRK_MODE, BRK_USER,
    input  REQ_READY, MBOX_REQ, MBOX_VMA, MBOX_FLAGS, HELD_VMA, HELD_FLAGS,
           COUNT, PAGE_ADDRESS_COND
  );

  modport slave (
    input  REQ_VALID, REQ_VMA, REQ_FLAGS, MBOX_ACK, FLUSH,
           BRK_LOAD, BRK_SEL, BRK_VMA, BRK_MODE, BRK_USER,
    output REQ_READY, MBOX_REQ, MBOX_VMA, MBOX_FLAGS, HELD_VMA, HELD_FLAGS,
           COUNT, PAGE_ADDRESS_COND
  );
endinterface

// File: rtl/mcl_cycle_queue.sv
// In-order EBOX memory-cycle request queue toward the MBOX with VMA HELD copy.
// Define MCL_ADR_BRK_EN to build the address-break channels and page-address stall.
module mcl_cycle_queue #(
  parameter int unsigned VMA_W = 23,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCOMP = 2
) (
  input logic              clk,
  input logic              RESET_N,
  mcl_cycle_queue_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Context-word bit positions (flag bit n lives at index n-1)
  localparam int unsigned F_LOAD_AR  = 0;
  localparam int unsigned F_LOAD_ARX = 1;
  localparam int unsigned F_WRITE    = 3;
  localparam int unsigned F_USER     = 4;
  localparam int unsigned F_FETCH    = 8;
  localparam int unsigned F_MAP      = 9;

  typedef struct packed {
    logic             brk;
    logic [11:0]      flags;
    logic [VMA_W-1:0] vma;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [VMA_W-1:0] held_vma_q;
  logic [11:0]      held_flags_q;
  logic             stall_q;
  logic             tag_c;
  logic             ready_c;
  logic             mbox_req_c;
  logic             push_c;
  logic             pop_c;
  entry_t           head_c;

  assign head_c     = mem_q[rd_ptr_q];
  assign ready_c    = (count_q != CNT_W'(DEPTH));
  assign mbox_req_c = (count_q != '0) & ~head_c.brk & ~stall_q;
  assign push_c     = bus.REQ_VALID & ready_c & ~bus.FLUSH;
  assign pop_c      = mbox_req_c & bus.MBOX_ACK & ~bus.FLUSH;

  assign bus.REQ_READY         = ready_c;
  assign bus.MBOX_REQ          = mbox_req_c;
  assign bus.MBOX_VMA          = head_c.vma;
  assign bus.MBOX_FLAGS        = head_c.flags;
  assign bus.HELD_VMA          = held_vma_q;
  assign bus.HELD_FLAGS        = held_flags_q;
  assign bus.COUNT             = count_q;
  assign bus.PAGE_ADDRESS_COND = stall_q;

  // Queue storage, pointers, occupancy and HELD copy
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      held_vma_q   <= '0;
      held_flags_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (bus.FLUSH) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i].brk <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= '{brk: tag_c, flags: bus.REQ_FLAGS, vma: bus.REQ_VMA};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        held_vma_q   <= head_c.vma;
        held_flags_q <= head_c.flags;
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) count_q <= count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_q <= count_q - CNT_W'(1);
    end
  end

`ifdef MCL_ADR_BRK_EN
  localparam int unsigned SEL_W = (NCOMP > 1) ? $clog2(NCOMP) : 1;

  logic [VMA_W-1:0] brk_vma_q  [NCOMP];
  logic [2:0]       brk_mode_q [NCOMP];
  logic [NCOMP-1:0] brk_user_q;

  // Push-time compare against the channel values held before this edge
  always_comb begin
    tag_c = 1'b0;
    for (int c = 0; c < int'(NCOMP); c++) begin
      if ((brk_mode_q[c] != 3'b000) &&
          (bus.REQ_VMA == brk_vma_q[c]) &&
          (bus.REQ_FLAGS[F_USER] == brk_user_q[c]) &&
          !bus.REQ_FLAGS[F_MAP] &&
          ((brk_mode_q[c][2] && bus.REQ_FLAGS[F_FETCH]) ||
           (brk_mode_q[c][0] && bus.REQ_FLAGS[F_WRITE]) ||
           (brk_mode_q[c][1] && !bus.REQ_FLAGS[F_FETCH] &&
            (bus.REQ_FLAGS[F_LOAD_AR] || bus.REQ_FLAGS[F_LOAD_ARX]))))
        tag_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      brk_user_q <= '0;
      for (int c = 0; c < int'(NCOMP); c++) begin
        brk_vma_q[c]  <= '0;
        brk_mode_q[c] <= '0;
      end
    end else if (bus.BRK_LOAD && (32'(bus.BRK_SEL) < NCOMP)) begin
      brk_vma_q[bus.BRK_SEL]  <= bus.BRK_VMA;
      brk_mode_q[bus.BRK_SEL] <= bus.BRK_MODE;
      brk_user_q[bus.BRK_SEL] <= bus.BRK_USER;
    end
  end

  // Stall latches once a tagged entry sits at the head; only FLUSH or reset clear it
  always_ff @(posedge clk) begin
    if (!RESET_N)                             stall_q <= 1'b0;
    else if (bus.FLUSH)                       stall_q <= 1'b0;
    else if ((count_q != '0) && head_c.brk)   stall_q <= 1'b1;
  end
`else
  logic unused_brk_c;

  assign tag_c        = 1'b0;
  assign stall_q      = 1'b0;
  assign unused_brk_c = ^{bus.BRK_LOAD, bus.BRK_SEL, bus.BRK_VMA, bus.BRK_MODE, bus.BRK_USER};
`endif

endmodule

// File: tb/tb_mcl_cycle_queue.sv
// Directed bench for mcl_cycle_queue with a reference scoreboard of queued cycles.
// Break-stall expectations follow MCL_ADR_BRK_EN the same way the design does.
module tb_mcl_cycle_queue;
  localparam int unsigned VMA_W = 23;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCOMP = 2;

  localparam logic [11:0] FL_LOAD_AR = 12'h001;
  localparam logic [11:0] FL_WRITE   = 12'h008;
  localparam logic [11:0] FL_FETCH   = 12'h100;
  localparam logic [11:0] FL_MAP     = 12'h200;

  typedef struct packed {
    logic             tag;
    logic [11:0]      flags;
    logic [VMA_W-1:0] vma;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  exp_t             sb[$];
  logic             m_stall;
  logic [VMA_W-1:0] m_held_vma;
  logic [11:0]      m_held_flags;
  logic [VMA_W-1:0] m_brk_vma  [NCOMP];
  logic [2:0]       m_brk_mode [NCOMP];
  logic             m_brk_user [NCOMP];

  mcl_cycle_queue_if #(.VMA_W(VMA_W), .DEPTH(DEPTH), .NCOMP(NCOMP)) q ();

  mcl_cycle_queue #(.VMA_W(VMA_W), .DEPTH(DEPTH), .NCOMP(NCOMP)) dut (
    .clk     (clk),
    .RESET_N (rst_n),
    .bus     (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_tag(input logic [VMA_W-1:0] vma, input logic [11:0] f);
    logic t;
    t = 1'b0;
`ifdef MCL_ADR_BRK_EN
    for (int c = 0; c < int'(NCOMP); c++) begin
      if (m_brk_mode[c] != 3'b000 && m_brk_vma[c] == vma && f[4] == m_brk_user[c] && !f[9]) begin
        if ((m_brk_mode[c][2] && f[8]) || (m_brk_mode[c][0] && f[3]) ||
            (m_brk_mode[c][1] && !f[8] && (f[0] || f[1])))
          t = 1'b1;
      end
    end
`endif
    return t;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_stall      = 1'b0;
    m_held_vma   = '0;
    m_held_flags = '0;
    for (int c = 0; c < int'(NCOMP); c++) begin
      m_brk_vma[c]  = '0;
      m_brk_mode[c] = '0;
      m_brk_user[c] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string ph);
    logic exp_req;
    exp_req = (sb.size() != 0) && !sb[0].tag && !m_stall;
    chk({ph, ".count"}, 32'(q.COUNT), 32'(sb.size()));
    chk({ph, ".ready"}, 32'(q.REQ_READY), 32'(sb.size() != int'(DEPTH)));
    chk({ph, ".mbox_req"}, 32'(q.MBOX_REQ), 32'(exp_req));
    chk({ph, ".pac"}, 32'(q.PAGE_ADDRESS_COND), 32'(m_stall));
    chk({ph, ".held_vma"}, 32'(q.HELD_VMA), 32'(m_held_vma));
    chk({ph, ".held_flags"}, 32'(q.HELD_FLAGS), 32'(m_held_flags));
    if (exp_req) begin
      chk({ph, ".head_vma"}, 32'(q.MBOX_VMA), 32'(sb[0].vma));
      chk({ph, ".head_flags"}, 32'(q.MBOX_FLAGS), 32'(sb[0].flags));
    end
  endtask

  // One clock: drive inputs, advance the model on pre-edge state, check after the edge
  task automatic cyc(input string ph, input logic valid, input logic [VMA_W-1:0] vma,
                     input logic [11:0] flags, input logic ack, input logic flush);
    logic exp_req, push, pop, tag;
    exp_t e;
    q.REQ_VALID = valid;
    q.REQ_VMA   = vma;
    q.REQ_FLAGS = flags;
    q.MBOX_ACK  = ack;
    q.FLUSH     = flush;
    exp_req = (sb.size() != 0) && !sb[0].tag && !m_stall;
    push    = valid && (sb.size() != int'(DEPTH)) && !flush;
    pop     = exp_req && ack && !flush;
    tag     = model_tag(vma, flags);
    if (pop) begin
      e = sb[0];
      chk({ph, ".issue_vma"}, 32'(q.MBOX_VMA), 32'(e.vma));
      chk({ph, ".issue_flags"}, 32'(q.MBOX_FLAGS), 32'(e.flags));
    end
    if (flush) begin
      sb.delete();
      m_stall = 1'b0;
    end else begin
      if (sb.size() != 0 && sb[0].tag) m_stall = 1'b1;
      if (pop) begin
        m_held_vma   = sb[0].vma;
        m_held_flags = sb[0].flags;
        void'(sb.pop_front());
      end
      if (push) sb.push_back('{tag: tag, flags: flags, vma: vma});
    end
    @(posedge clk);
    #1;
    q.REQ_VALID = 1'b0;
    q.MBOX_ACK  = 1'b0;
    q.FLUSH     = 1'b0;
    q.BRK_LOAD  = 1'b0;
    check_outputs(ph);
  endtask

  task automatic load_brk(input int sel, input logic [VMA_W-1:0] vma, input logic [2:0] mode,
                          input logic user);
    q.BRK_LOAD = 1'b1;
    q.BRK_SEL  = 1'(sel);
    q.BRK_VMA  = vma;
    q.BRK_MODE = mode;
    q.BRK_USER = user;
    cyc("brk_load", 1'b0, '0, '0, 1'b0, 1'b0);
    if (sel < int'(NCOMP)) begin
      m_brk_vma[sel]  = vma;
      m_brk_mode[sel] = mode;
      m_brk_user[sel] = user;
    end
  endtask

  task automatic do_reset(input string ph);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_outputs(ph);
    chk({ph, ".mbox_vma0"}, 32'(q.MBOX_VMA), 32'h0);
    chk({ph, ".mbox_flags0"}, 32'(q.MBOX_FLAGS), 32'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    q.REQ_VALID = 1'b0;
    q.REQ_VMA   = '0;
    q.REQ_FLAGS = '0;
    q.MBOX_ACK  = 1'b0;
    q.FLUSH     = 1'b0;
    q.BRK_LOAD  = 1'b0;
    q.BRK_SEL   = '0;
    q.BRK_VMA   = '0;
    q.BRK_MODE  = '0;
    q.BRK_USER  = 1'b0;
    model_reset();
    @(posedge clk);
    do_reset("reset");

    // Fill to capacity without acks, then drain in order
    for (int i = 0; i < 4; i++) cyc("fill", 1'b1, VMA_W'(32'h100 + i), 12'(i), 1'b0, 1'b0);
    chk("full.count", 32'(q.COUNT), 32'd4);
    chk("full.ready", 32'(q.REQ_READY), 32'd0);
    for (int i = 0; i < 4; i++) cyc("drain", 1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain.held_vma", 32'(q.HELD_VMA), 32'h103);
    chk("drain.count", 32'(q.COUNT), 32'd0);

    // Full queue: push refused while the ack still pops
    for (int i = 0; i < 4; i++) cyc("refill", 1'b1, VMA_W'(32'h200 + i), 12'h0, 1'b0, 1'b0);
    cyc("full_push_ack", 1'b1, VMA_W'(32'h2ff), 12'h0, 1'b1, 1'b0);
    chk("full_push_ack.count", 32'(q.COUNT), 32'd3);
    for (int i = 0; i < 3; i++) cyc("drain2", 1'b0, '0, '0, 1'b1, 1'b0);

    // Empty-to-issue latency and HELD flags
    cyc("lat_push", 1'b1, VMA_W'(32'h2000), FL_FETCH, 1'b0, 1'b0);
    chk("lat.mbox_req", 32'(q.MBOX_REQ), 32'd1);
    cyc("lat_ack", 1'b0, '0, '0, 1'b1, 1'b0);
    chk("lat.mbox_req_after", 32'(q.MBOX_REQ), 32'd0);
    chk("lat.held_fetch", 32'(q.HELD_FLAGS[8]), 32'd1);

    // Simultaneous push/pop under FLUSH: both dropped, HELD kept
    cyc("fl_a", 1'b1, VMA_W'(32'h500), 12'h0, 1'b0, 1'b0);
    cyc("fl_b", 1'b1, VMA_W'(32'h501), 12'h0, 1'b0, 1'b0);
    cyc("fl_all", 1'b1, VMA_W'(32'h502), 12'h0, 1'b1, 1'b1);
    chk("fl_all.held_vma", 32'(q.HELD_VMA), 32'h2000);

    // Address break on a write behind two untagged entries
    load_brk(1, VMA_W'(32'h40), 3'b001, 1'b0);
    cyc("brk_a", 1'b1, VMA_W'(32'h300), 12'h0, 1'b0, 1'b0);
    cyc("brk_b", 1'b1, VMA_W'(32'h301), 12'h0, 1'b0, 1'b0);
    cyc("brk_w", 1'b1, VMA_W'(32'h40), FL_WRITE, 1'b0, 1'b0);
    cyc("brk_ack_a", 1'b0, '0, '0, 1'b1, 1'b0);
    cyc("brk_ack_b", 1'b0, '0, '0, 1'b1, 1'b0);
    chk("brk.held_b", 32'(q.HELD_VMA), 32'h301);
`ifdef MCL_ADR_BRK_EN
    chk("brk.head_blocked", 32'(q.MBOX_REQ), 32'd0);
`endif
    cyc("brk_wait1", 1'b0, '0, '0, 1'b1, 1'b0);
    cyc("brk_wait2", 1'b0, '0, '0, 1'b1, 1'b0);
`ifdef MCL_ADR_BRK_EN
    chk("brk.pac", 32'(q.PAGE_ADDRESS_COND), 32'd1);
    chk("brk.stuck_count", 32'(q.COUNT), 32'd1);
`else
    chk("brk.issued", 32'(q.HELD_VMA), 32'h40);
`endif
    cyc("brk_flush", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("brk_flush.count", 32'(q.COUNT), 32'd0);
    chk("brk_flush.pac", 32'(q.PAGE_ADDRESS_COND), 32'd0);

    // Read and mapped write to the break address are not tagged
    cyc("nt_read", 1'b1, VMA_W'(32'h40), FL_LOAD_AR, 1'b0, 1'b0);
    cyc("nt_map", 1'b1, VMA_W'(32'h40), FL_WRITE | FL_MAP, 1'b1, 1'b0);
    cyc("nt_ack", 1'b0, '0, '0, 1'b1, 1'b0);
    chk("nt.held_flags", 32'(q.HELD_FLAGS), 32'(FL_WRITE | FL_MAP));
    chk("nt.count", 32'(q.COUNT), 32'd0);

    // Reset with entries queued clears queue, HELD and break channels
    for (int i = 0; i < 3; i++) cyc("pre_rst", 1'b1, VMA_W'(32'h600 + i), FL_WRITE, 1'b0, 1'b0);
    do_reset("mid_reset");
    chk("mid_reset.held_vma", 32'(q.HELD_VMA), 32'h0);
    cyc("post_rst_w", 1'b1, VMA_W'(32'h40), FL_WRITE, 1'b0, 1'b0);
    chk("post_rst.issue", 32'(q.MBOX_REQ), 32'd1);
    cyc("post_rst_ack", 1'b0, '0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
